// File: rtl/bsx_stream.sv
// Satellaview stream channel registers with a single-port prefetch engine.
// Each channel keeps STA/STB/DAT one-byte buffers refilled from paged memory.
module bsx_stream #(
  parameter int               NCH     = 2,
  parameter int               PAGE_W  = 10,
  parameter int               OFF_W   = 9,
  parameter logic [OFF_W-1:0] STA_OFF = 9'h032,
  parameter logic [OFF_W-1:0] STB_OFF = 9'h034,
  parameter int               STB_LEN = 20,
  parameter logic [OFF_W-1:0] DAT_OFF = 9'h048
) (
  input  logic                    clkin,
  input  logic                    rst,
  input  logic                    use_bsx,
  input  logic [23:0]             snes_addr,
  input  logic                    reg_oe_falling,
  input  logic                    reg_oe_rising,
  input  logic                    reg_we_rising,
  input  logic [7:0]              reg_data_in,
  output logic [7:0]              reg_data_out,
  output logic                    data_ovr,
  output logic                    mem_req,
  output logic [PAGE_W+OFF_W-1:0] mem_addr,
  input  logic                    mem_ack,
  input  logic [7:0]              mem_data
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SW = (STB_LEN > 1) ? $clog2(STB_LEN) : 1;
  localparam int AW = PAGE_W + OFF_W;
  localparam logic [1:0] B_STA = 2'd0, B_STB = 2'd1, B_DAT = 2'd2;

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t            state_q, state_d;
  logic [PAGE_W-1:0] page_q [NCH], page_d [NCH];
  logic [7:0]        chl_q [NCH], chl_d [NCH], chh_q [NCH], chh_d [NCH];
  logic [7:0]        pfx_q [NCH], pfx_d [NCH];
  logic [SW-1:0]     stb_off_q [NCH], stb_off_d [NCH];
  logic [OFF_W-1:0]  dat_off_q [NCH], dat_off_d [NCH];
  logic [7:0]        sta_buf_q [NCH], sta_buf_d [NCH], stb_buf_q [NCH], stb_buf_d [NCH];
  logic [7:0]        dat_buf_q [NCH], dat_buf_d [NCH];
  logic [NCH-1:0]    sta_v_q, sta_v_d, stb_v_q, stb_v_d, dat_v_q, dat_v_d;
  logic [1:0]        gen_q [NCH], gen_d [NCH];
  logic              mem_req_q, mem_req_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [CW-1:0]     rr_q, rr_d, tgt_ch_q, tgt_ch_d;
  logic [1:0]        tgt_buf_q, tgt_buf_d, tgt_gen_q, tgt_gen_d;

  logic              hit;
  logic [CW-1:0]     hit_ch;
  logic [2:0]        hit_reg;
  logic              sel_found;
  logic [CW-1:0]     sel_ch;
  logic [1:0]        sel_buf;
  logic [OFF_W-1:0]  sel_off;
  int                idx;
  logic              unused_addr;

  assign unused_addr  = ^{snes_addr[23], snes_addr[21:16]};
  assign data_ovr     = use_bsx & hit;
  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;
  assign reg_data_out = rdata_q;

  always_comb begin
    hit     = 1'b0;
    hit_ch  = '0;
    hit_reg = 3'd0;
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < 6; k++) begin
        if (snes_addr[15:0] == 16'(32'h2188 + 6 * c + k)) begin
          hit     = ~snes_addr[22];
          hit_ch  = CW'(c);
          hit_reg = 3'(k);
        end
      end
    end
  end

  // Round-robin channel pick starting at rr_q; DAT beats STB beats STA.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    sel_buf   = B_STA;
    idx       = 0;
    for (int i = 0; i < NCH; i++) begin
      idx = (int'(rr_q) + i) % NCH;
      if (!sel_found && (page_q[idx] != '0) && !(sta_v_q[idx] && stb_v_q[idx] && dat_v_q[idx])) begin
        sel_found = 1'b1;
        sel_ch    = CW'(idx);
        if (!dat_v_q[idx])      sel_buf = B_DAT;
        else if (!stb_v_q[idx]) sel_buf = B_STB;
        else                    sel_buf = B_STA;
      end
    end
    case (sel_buf)
      B_DAT:   sel_off = DAT_OFF + dat_off_q[sel_ch];
      B_STB:   sel_off = STB_OFF + OFF_W'(stb_off_q[sel_ch]);
      default: sel_off = STA_OFF;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    page_d     = page_q;
    chl_d      = chl_q;
    chh_d      = chh_q;
    pfx_d      = pfx_q;
    stb_off_d  = stb_off_q;
    dat_off_d  = dat_off_q;
    sta_buf_d  = sta_buf_q;
    stb_buf_d  = stb_buf_q;
    dat_buf_d  = dat_buf_q;
    sta_v_d    = sta_v_q;
    stb_v_d    = stb_v_q;
    dat_v_d    = dat_v_q;
    gen_d      = gen_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    rdata_d    = rdata_q;
    rr_d       = rr_q;
    tgt_ch_d   = tgt_ch_q;
    tgt_buf_d  = tgt_buf_q;
    tgt_gen_d  = tgt_gen_q;

    case (state_q)
      S_IDLE: begin
        if (use_bsx && sel_found) begin
          state_d    = S_REQ;
          mem_req_d  = 1'b1;
          tgt_ch_d   = sel_ch;
          tgt_buf_d  = sel_buf;
          tgt_gen_d  = gen_q[sel_ch];
          mem_addr_d = {page_q[sel_ch], sel_off};
          rr_d       = (int'(sel_ch) == NCH - 1) ? '0 : sel_ch + CW'(1);
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          // A CHH rewrite while waiting makes the returning byte stale.
          if (gen_q[tgt_ch_q] == tgt_gen_q) begin
            case (tgt_buf_q)
              B_DAT: begin dat_buf_d[tgt_ch_q] = mem_data; dat_v_d[tgt_ch_q] = 1'b1; end
              B_STB: begin stb_buf_d[tgt_ch_q] = mem_data; stb_v_d[tgt_ch_q] = 1'b1; end
              default: begin sta_buf_d[tgt_ch_q] = mem_data; sta_v_d[tgt_ch_q] = 1'b1; end
            endcase
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    // Register side is applied after the fill so a same-cycle CHH write wins.
    if (use_bsx && hit) begin
      if (reg_we_rising) begin
        case (hit_reg)
          3'd0: chl_d[hit_ch] = reg_data_in;
          3'd1: begin
            chh_d[hit_ch]     = reg_data_in;
            page_d[hit_ch]    = PAGE_W'({reg_data_in, chl_q[hit_ch]});
            stb_off_d[hit_ch] = '0;
            dat_off_d[hit_ch] = '0;
            sta_v_d[hit_ch]   = 1'b0;
            stb_v_d[hit_ch]   = 1'b0;
            dat_v_d[hit_ch]   = 1'b0;
            gen_d[hit_ch]     = gen_q[hit_ch] + 2'd1;
          end
          default: ;
        endcase
      end
      if (reg_oe_falling) begin
        case (hit_reg)
          3'd0:    rdata_d = chl_q[hit_ch];
          3'd1:    rdata_d = chh_q[hit_ch];
          3'd2:    rdata_d = (sta_v_q[hit_ch] && page_q[hit_ch] != '0) ? sta_buf_q[hit_ch] : 8'h00;
          3'd3:    rdata_d = (stb_v_q[hit_ch] && page_q[hit_ch] != '0) ? stb_buf_q[hit_ch] : 8'h00;
          3'd4:    rdata_d = (dat_v_q[hit_ch] && page_q[hit_ch] != '0) ? dat_buf_q[hit_ch] : 8'h00;
          default: rdata_d = pfx_q[hit_ch];
        endcase
      end
      if (reg_oe_rising) begin
        case (hit_reg)
          3'd2: begin
            if (sta_v_q[hit_ch]) sta_v_d[hit_ch] = 1'b0;
            else                 pfx_d[hit_ch][0] = 1'b1;
          end
          3'd3: begin
            if (stb_v_q[hit_ch]) begin
              stb_v_d[hit_ch]   = 1'b0;
              pfx_d[hit_ch]     = pfx_q[hit_ch] | stb_buf_q[hit_ch];
              stb_off_d[hit_ch] = (stb_off_q[hit_ch] == SW'(STB_LEN - 1)) ? '0
                                  : stb_off_q[hit_ch] + SW'(1);
            end else begin
              pfx_d[hit_ch][0] = 1'b1;
            end
          end
          3'd4: begin
            if (dat_v_q[hit_ch]) begin
              dat_v_d[hit_ch]   = 1'b0;
              dat_off_d[hit_ch] = dat_off_q[hit_ch] + OFF_W'(1);
            end else begin
              pfx_d[hit_ch][0] = 1'b1;
            end
          end
          3'd5:    pfx_d[hit_ch] = 8'h00;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sta_v_q    <= '0;
      stb_v_q    <= '0;
      dat_v_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      rdata_q    <= 8'h00;
      rr_q       <= '0;
      tgt_ch_q   <= '0;
      tgt_buf_q  <= 2'd0;
      tgt_gen_q  <= 2'd0;
      for (int c = 0; c < NCH; c++) begin
        page_q[c]    <= '0;
        chl_q[c]     <= 8'h00;
        chh_q[c]     <= 8'h00;
        pfx_q[c]     <= 8'h00;
        stb_off_q[c] <= '0;
        dat_off_q[c] <= '0;
        sta_buf_q[c] <= 8'h00;
        stb_buf_q[c] <= 8'h00;
        dat_buf_q[c] <= 8'h00;
        gen_q[c]     <= 2'd0;
      end
    end else begin
      state_q    <= state_d;
      page_q     <= page_d;
      chl_q      <= chl_d;
      chh_q      <= chh_d;
      pfx_q      <= pfx_d;
      stb_off_q  <= stb_off_d;
      dat_off_q  <= dat_off_d;
      sta_buf_q  <= sta_buf_d;
      stb_buf_q  <= stb_buf_d;
      dat_buf_q  <= dat_buf_d;
      sta_v_q    <= sta_v_d;
      stb_v_q    <= stb_v_d;
      dat_v_q    <= dat_v_d;
      gen_q      <= gen_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      rdata_q    <= rdata_d;
      rr_q       <= rr_d;
      tgt_ch_q   <= tgt_ch_d;
      tgt_buf_q  <= tgt_buf_d;
      tgt_gen_q  <= tgt_gen_d;
    end
  end
endmodule

// File: tb/tb_bsx_stream.sv
// Scoreboard bench for bsx_stream: expected fetch addresses and read bytes are
// queued by the stimulus and popped by a monitor when the DUT presents them.
module tb_bsx_stream;
  logic        clkin = 1'b0;
  logic        rst = 1'b1;
  logic        use_bsx = 1'b0;
  logic [23:0] snes_addr = 24'h000000;
  logic        reg_oe_falling = 1'b0, reg_oe_rising = 1'b0, reg_we_rising = 1'b0;
  logic [7:0]  reg_data_in = 8'h00;
  logic [7:0]  reg_data_out;
  logic        data_ovr;
  logic        mem_req;
  logic [18:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_data = 8'h00;

  int total = 0;
  int bad = 0;
  logic [18:0] exp_addr_q[$];
  logic [7:0]  exp_rd_q[$];
  logic        rd_ev = 1'b0;
  logic        prev_req = 1'b0;

  always #5 clkin = ~clkin;

  bsx_stream dut (
    .clkin(clkin), .rst(rst), .use_bsx(use_bsx), .snes_addr(snes_addr),
    .reg_oe_falling(reg_oe_falling), .reg_oe_rising(reg_oe_rising),
    .reg_we_rising(reg_we_rising), .reg_data_in(reg_data_in),
    .reg_data_out(reg_data_out), .data_ovr(data_ovr), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] ma(input logic [9:0] p, input logic [8:0] o);
    return {p, o};
  endfunction

  always @(posedge clkin) rd_ev <= reg_oe_falling && use_bsx;

  // Monitor: compare each read strobe and each new fetch request with the queues.
  always @(negedge clkin) begin
    if (rd_ev) begin
      if (exp_rd_q.size() == 0) check("rd_unexpected", {24'h0, reg_data_out}, 32'hFFFF_FFFF);
      else check("rd_data", {24'h0, reg_data_out}, {24'h0, exp_rd_q.pop_front()});
    end
    if (mem_req && !prev_req) begin
      if (exp_addr_q.size() == 0) check("req_unexpected", {13'h0, mem_addr}, 32'hFFFF_FFFF);
      else check("mem_addr", {13'h0, mem_addr}, {13'h0, exp_addr_q.pop_front()});
    end
    prev_req <= mem_req;
  end

  task automatic cyc();
    @(posedge clkin);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    snes_addr = {8'h00, a};
    reg_data_in = d;
    reg_we_rising = 1'b1;
    cyc();
    reg_we_rising = 1'b0;
    cyc();
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] e);
    snes_addr = {8'h00, a};
    exp_rd_q.push_back(e);
    reg_oe_falling = 1'b1;
    cyc();
    reg_oe_falling = 1'b0;
    reg_oe_rising = 1'b1;
    cyc();
    reg_oe_rising = 1'b0;
    cyc();
  endtask

  task automatic wait_req();
    int n = 0;
    while (!mem_req && n < 50) begin
      cyc();
      n++;
    end
    if (!mem_req) check("req_timeout", {31'h0, mem_req}, 32'h1);
  endtask

  task automatic ack(input logic [7:0] d);
    wait_req();
    mem_ack = 1'b1;
    mem_data = d;
    cyc();
    mem_ack = 1'b0;
    cyc();
  endtask

  initial begin
    repeat (3) cyc();
    check("rst_rdata", {24'h0, reg_data_out}, 32'h0);
    check("rst_req", {31'h0, mem_req}, 32'h0);
    check("rst_addr", {13'h0, mem_addr}, 32'h0);
    rst = 1'b0;
    snes_addr = 24'h00218C;
    #1 check("ovr_off", {31'h0, data_ovr}, 32'h0);
    use_bsx = 1'b1;
    #1 check("ovr_dat", {31'h0, data_ovr}, 32'h1);
    snes_addr = 24'h002193;
    #1 check("ovr_ch1_pfx", {31'h0, data_ovr}, 32'h1);
    snes_addr = 24'h002194;
    #1 check("ovr_ch2", {31'h0, data_ovr}, 32'h0);
    snes_addr = 24'h402188;
    #1 check("ovr_bank", {31'h0, data_ovr}, 32'h0);
    cyc();

    // Channel 0 at page 5: DAT, STB, STA fill order.
    exp_addr_q.push_back(ma(10'h005, 9'h048));
    exp_addr_q.push_back(ma(10'h005, 9'h034));
    exp_addr_q.push_back(ma(10'h005, 9'h032));
    wr(16'h2188, 8'h05);
    wr(16'h2189, 8'h00);
    ack(8'hA5);
    ack(8'h01);
    ack(8'h5A);
    exp_addr_q.push_back(ma(10'h005, 9'h049));
    rd(16'h218C, 8'hA5);
    ack(8'h3C);
    exp_addr_q.push_back(ma(10'h005, 9'h032));
    rd(16'h218A, 8'h5A);
    ack(8'h11);

    // STB walks 20 bytes and wraps back to offset 0x034.
    for (int i = 1; i <= 20; i++) begin
      exp_addr_q.push_back(ma(10'h005, 9'(9'h034 + (i % 20))));
      rd(16'h218B, 8'(i));
      ack((i == 20) ? 8'hEE : 8'(i + 1));
    end
    rd(16'h218D, 8'h1F);
    rd(16'h218D, 8'h00);

    // CHH rewrite while a DAT fetch is outstanding.
    exp_addr_q.push_back(ma(10'h005, 9'h04A));
    rd(16'h218C, 8'h3C);
    wait_req();
    exp_addr_q.push_back(ma(10'h105, 9'h048));
    wr(16'h2189, 8'h01);
    ack(8'h77);
    rd(16'h218C, 8'h00);
    rd(16'h218D, 8'h01);

    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst2_req", {31'h0, mem_req}, 32'h0);
    cyc();

    // Two live channels: round-robin across channels, DAT before STB before STA.
    exp_addr_q.push_back(ma(10'h005, 9'h048));
    wr(16'h2188, 8'h05);
    wr(16'h2189, 8'h00);
    exp_addr_q.push_back(ma(10'h222, 9'h048));
    exp_addr_q.push_back(ma(10'h005, 9'h034));
    exp_addr_q.push_back(ma(10'h222, 9'h034));
    exp_addr_q.push_back(ma(10'h005, 9'h032));
    exp_addr_q.push_back(ma(10'h222, 9'h032));
    wr(16'h218E, 8'h22);
    wr(16'h218F, 8'h02);
    ack(8'h10);
    ack(8'h20);
    ack(8'h30);
    ack(8'h40);
    ack(8'h50);
    ack(8'h60);
    exp_addr_q.push_back(ma(10'h222, 9'h049));
    rd(16'h2192, 8'h20);
    wait_req();

    // Reads with use_bsx low leave reg_data_out alone.
    use_bsx = 1'b0;
    snes_addr = 24'h002190;
    reg_oe_falling = 1'b1;
    cyc();
    reg_oe_falling = 1'b0;
    check("nobsx_hold", {24'h0, reg_data_out}, 32'h20);
    use_bsx = 1'b1;

    // Reset mid-request, then a late ack must not revive anything.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst3_req", {31'h0, mem_req}, 32'h0);
    check("rst3_rdata", {24'h0, reg_data_out}, 32'h0);
    mem_ack = 1'b1;
    mem_data = 8'h99;
    cyc();
    mem_ack = 1'b0;
    repeat (5) cyc();
    check("late_ack_req", {31'h0, mem_req}, 32'h0);
    rd(16'h2192, 8'h00);

    cyc();
    check("addr_q_left", exp_addr_q.size(), 32'h0);
    check("rd_q_left", exp_rd_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/bsx_stream.md
BSX_STREAM -- requirements
Module: bsx_stream

Interface
REQ-001 SHALL have parameter NCH, default 2, number of satellite channels (legal 1..4).
REQ-002 SHALL have parameter PAGE_W, default 10, channel page number width.
REQ-003 SHALL have parameter OFF_W, default 9, byte offset within a page.
REQ-004 SHALL have parameters STA_OFF=9'h032, STB_OFF=9'h034, STB_LEN=20, DAT_OFF=9'h048: stream layout within a page.
REQ-005 SHALL have port clkin  in  1  system clock; the block has one clock.
REQ-006 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-007 SHALL have ports use_bsx in 1; snes_addr in 24; reg_oe_falling, reg_oe_rising, reg_we_rising in 1 each; reg_data_in in 8.
REQ-008 SHALL have ports reg_data_out out 8 (registered read data) and data_ovr out 1 (block drives SNES bus).
REQ-009 SHALL have ports mem_req out 1, mem_addr out PAGE_W+OFF_W ({page, offset}), mem_ack in 1, mem_data in 8 (valid with mem_ack).

Function
REQ-010 SHALL decode channel c register k at $2188+6c+k (k=0 CHL, 1 CHH, 2 STA, 3 STB, 4 DAT, 5 PFX), banks with snes_addr[22]=0, c<NCH only.
REQ-011 SHALL assert data_ovr combinationally iff use_bsx and snes_addr hits a decoded register.
REQ-012 SHALL per channel hold page[PAGE_W], stb_off (0..STB_LEN-1), dat_off[OFF_W], PFX[8], and three one-byte prefetch buffers (STA, STB, DAT) each with a valid bit.
REQ-013 SHALL on CHL write store the byte only; on CHH write set page={CHH bits, CHL}, clear stb_off, dat_off, all three valid bits, and bump a 2-bit channel generation tag.
REQ-014 SHALL treat page==0 as channel idle: no fetches issued; STA, STB, DAT reads return 8'h00.
REQ-015 SHALL on reg_oe_falling at a decoded address load reg_data_out: CHL/CHH stored bytes; STA/STB/DAT buffer byte if valid else 8'h00; PFX current value.
REQ-016 SHALL on reg_oe_rising consume: STA clears valid; STB clears valid, ORs byte into PFX, stb_off wraps STB_LEN-1 -> 0; DAT clears valid, dat_off+1 modulo 2^OFF_W; PFX clears to 8'h00.
REQ-017 SHALL not advance offsets or modify PFX when the consumed buffer was invalid (underrun); instead set PFX[0]=1.
REQ-018 SHALL run a fetch FSM IDLE -> REQ -> IDLE: in IDLE select one invalid buffer of a non-idle channel, latch target and generation tag, assert mem_req next cycle.
REQ-019 SHALL arbitrate round-robin across channels (pointer advances past the served channel) and DAT > STB > STA within a channel.
REQ-020 SHALL drive mem_addr = {page, STA_OFF | STB_OFF+stb_off | DAT_OFF+dat_off} with offset sum truncated to OFF_W bits, stable while mem_req=1.
REQ-021 SHALL hold mem_req until the cycle mem_ack=1, then deassert, write mem_data into the target buffer, set valid, return to IDLE.
REQ-022 SHALL discard returning data (valid stays 0) if the target channel's generation changed while in REQ.
REQ-023 SHALL give register access priority over fill: a consume and fill of the same buffer cannot coincide (fill targets only invalid buffers).
REQ-024 SHALL ignore all accesses and issue no fetches when use_bsx=0; reg_data_out holds.

Reset
REQ-025 SHALL on rst=1 at clkin edge: pages, CHL/CHH, offsets, PFX, generation to 0; all valid to 0; FSM IDLE; mem_req=0; mem_addr=0; reg_data_out=8'h00; RR pointer=0.
REQ-026 SHALL on rst mid-REQ drop mem_req next cycle and ignore any mem_ack that follows.

Verification
REQ-027 Write ch0 CHL=8'h05, CHH=8'h00 -> mem_req with mem_addr={10'h005,9'h048} first, then STB {005,034}, then STA {005,032}.
REQ-028 Ack DAT with 8'hA5, read $218C -> 8'hA5; next fetch addr offset 9'h049.
REQ-029 Read STB 20 times with data 8'h01..8'h14 -> offset wraps to 9'h034; PFX read = OR of bytes 8'h1F, second PFX read 8'h00.
REQ-030 Both channels valid pages, all buffers empty -> fetch order ch0 DAT, ch1 DAT, ch0 STB, ch1 STB.
REQ-031 CHH rewrite during REQ, then mem_ack 8'h77 -> DAT stays invalid, new request at new page, read returns 8'h00, PFX[0]=1.
REQ-032 rst asserted while mem_req=1 -> mem_req=0 next cycle, reg_data_out=8'h00, late mem_ack has no effect.
